compute: RTL and testbench

COMPUTE -- requirements
Module: compute

---
 rtl/compute.sv | 184 ++++++++++++++++++
 tb/tb_compute.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/compute.sv
// compute: one 3-tap smoothing pass over a source RAM into an intermediate
// (int) RAM, followed by a copy of the int RAM back into the source RAM.
// int[i] = (s[i-1] + 2*s[i] + s[i+1]) >>> 2, with out-of-range neighbours = 0.
//
// Memory interface: both RAMs have a 1-cycle registered read, so a read
// address presented in one cycle returns its data in the next cycle, and a
// write is taken at the rising edge where the write enable is high. There is
// no handshake; the run is paced entirely by the fixed read latency.
module compute #(
  parameter int LENGTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       START,
  input  logic [7:0] M10K_read_data_source,
  output logic [7:0] M10K_write_data_source_wire,
  output logic [7:0] M10K_read_address_source_wire,
  output logic [7:0] M10K_write_address_source_wire,
  output logic       M10K_write_source_wire,
  input  logic [7:0] M10K_read_data_int,
  output logic [7:0] M10K_write_data_int_wire,
  output logic [7:0] M10K_read_address_int_wire,
  output logic [7:0] M10K_write_address_int_wire,
  output logic       M10K_write_int_wire,
  output logic [1:0] state_dbg_o
);

  localparam logic [7:0] LAST = 8'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SMOOTH = 2'd1,
    COPY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_q;
  logic       start_prev_q;
  // read issue: rd_en_q marks a valid read address on the active RAM port
  logic       rd_en_q;
  logic [7:0] src_raddr_q;
  logic [7:0] int_raddr_q;
  // read return: data for index d_idx_q is on the RAM q port while d_v_q
  logic       d_v_q;
  logic [7:0] d_idx_q;
  // sliding window: wa_q = s[j-2], wb_q = s[j-1] while s[j] is on q
  logic [7:0] wa_q;
  logic [7:0] wb_q;
  // tail_q: emit int[LENGTH-1]; fin_q: last write is on the bus, leave phase
  logic       tail_q;
  logic       fin_q;
  logic       src_we_q;
  logic [7:0] src_waddr_q;
  logic [7:0] src_wdata_q;
  logic       int_we_q;
  logic [7:0] int_waddr_q;
  logic [7:0] int_wdata_q;

  logic [9:0] sum_full;
  logic [9:0] sum_tail;

  // 10-bit signed window sums; bits [9:2] are the floor-divided-by-4 result
  always_comb begin
    sum_full = {{2{wa_q[7]}}, wa_q} + {wb_q[7], wb_q, 1'b0}
             + {{2{M10K_read_data_source[7]}}, M10K_read_data_source};
    sum_tail = {{2{wa_q[7]}}, wa_q} + {wb_q[7], wb_q, 1'b0};
  end

  // control FSM, read pipeline, window and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      rd_en_q      <= 1'b0;
      src_raddr_q  <= '0;
      int_raddr_q  <= '0;
      d_v_q        <= 1'b0;
      d_idx_q      <= '0;
      wa_q         <= '0;
      wb_q         <= '0;
      tail_q       <= 1'b0;
      fin_q        <= 1'b0;
      src_we_q     <= 1'b0;
      src_waddr_q  <= '0;
      src_wdata_q  <= '0;
      int_we_q     <= 1'b0;
      int_waddr_q  <= '0;
      int_wdata_q  <= '0;
    end else begin
      start_prev_q <= START;
      d_v_q        <= rd_en_q;
      d_idx_q      <= (state_q == COPY) ? int_raddr_q : src_raddr_q;
      src_we_q     <= 1'b0;
      int_we_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (START && !start_prev_q) begin
            state_q     <= SMOOTH;
            rd_en_q     <= 1'b1;
            src_raddr_q <= '0;
            wa_q        <= '0;
            wb_q        <= '0;
            tail_q      <= 1'b0;
            fin_q       <= 1'b0;
          end
        end
        SMOOTH: begin
          // issue source reads 0..LENGTH-1, then park the address at 0
          if (rd_en_q) begin
            if (src_raddr_q == LAST) begin
              rd_en_q     <= 1'b0;
              src_raddr_q <= '0;
            end else begin
              src_raddr_q <= src_raddr_q + 8'd1;
            end
          end
          // s[j] has arrived: shift window and emit int[j-1]
          if (d_v_q) begin
            wa_q <= wb_q;
            wb_q <= M10K_read_data_source;
            if (d_idx_q != 8'd0) begin
              int_we_q    <= 1'b1;
              int_waddr_q <= d_idx_q - 8'd1;
              int_wdata_q <= sum_full[9:2];
            end
            if (d_idx_q == LAST) tail_q <= 1'b1;
          end
          // last cell uses 0 as its right neighbour
          if (tail_q) begin
            tail_q      <= 1'b0;
            fin_q       <= 1'b1;
            int_we_q    <= 1'b1;
            int_waddr_q <= LAST;
            int_wdata_q <= sum_tail[9:2];
          end
          if (fin_q) begin
            fin_q       <= 1'b0;
            state_q     <= COPY;
            rd_en_q     <= 1'b1;
            int_raddr_q <= '0;
            int_waddr_q <= '0;
          end
        end
        COPY: begin
          if (rd_en_q) begin
            if (int_raddr_q == LAST) begin
              rd_en_q     <= 1'b0;
              int_raddr_q <= '0;
            end else begin
              int_raddr_q <= int_raddr_q + 8'd1;
            end
          end
          // int[j] has arrived: write it back to source[j]
          if (d_v_q) begin
            src_we_q    <= 1'b1;
            src_waddr_q <= d_idx_q;
            src_wdata_q <= M10K_read_data_int;
            if (d_idx_q == LAST) fin_q <= 1'b1;
          end
          if (fin_q) begin
            fin_q       <= 1'b0;
            state_q     <= DONE;
            src_waddr_q <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M10K_write_data_source_wire    = src_wdata_q;
  assign M10K_read_address_source_wire  = src_raddr_q;
  assign M10K_write_address_source_wire = src_waddr_q;
  assign M10K_write_source_wire         = src_we_q;
  assign M10K_write_data_int_wire       = int_wdata_q;
  assign M10K_read_address_int_wire     = int_raddr_q;
  assign M10K_write_address_int_wire    = int_waddr_q;
  assign M10K_write_int_wire            = int_we_q;
  assign state_dbg_o                    = state_q;

endmodule

// File: tb/tb_compute.sv
// Bench for compute: behavioural RAMs, a reference smoothing model that
// fills an expected-write queue, and a negedge monitor that pops it.
module tb_compute;

  localparam int L = 256;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SMOOTH = 2'd1;
  localparam logic [1:0] ST_COPY   = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  // ---------------- DUT + RAM models ----------------
  logic [7:0] src_q, src_wdata, src_raddr, src_waddr;
  logic       src_we;
  logic [7:0] int_q, int_wdata, int_raddr, int_waddr;
  logic       int_we;
  logic [1:0] state;

  compute #(.LENGTH(L)) dut (
    .clk                            (clk),
    .reset                          (rst_n),
    .START                          (start),
    .M10K_read_data_source          (src_q),
    .M10K_write_data_source_wire    (src_wdata),
    .M10K_read_address_source_wire  (src_raddr),
    .M10K_write_address_source_wire (src_waddr),
    .M10K_write_source_wire         (src_we),
    .M10K_read_data_int             (int_q),
    .M10K_write_data_int_wire       (int_wdata),
    .M10K_read_address_int_wire     (int_raddr),
    .M10K_write_address_int_wire    (int_waddr),
    .M10K_write_int_wire            (int_we),
    .state_dbg_o                    (state)
  );

  logic [7:0] src_mem [L];
  logic [7:0] int_mem [L];
  logic [7:0] src_init [L];
  logic [7:0] src_model [L];
  logic       ld_all;

  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < L; i++) src_mem[i] <= src_init[i];
    end else if (src_we) begin
      src_mem[src_waddr] <= src_wdata;
    end
    src_q <= src_mem[src_raddr];
  end

  always @(posedge clk) begin
    if (int_we) int_mem[int_waddr] <= int_wdata;
    int_q <= int_mem[int_raddr];
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int smooth_cyc, copy_cyc, int_wr_cnt, src_wr_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_val("we_overlap", {31'd0, int_we & src_we}, 32'd0);
      if (state == ST_SMOOTH) begin
        smooth_cyc++;
        check_val("src_we_in_smooth", {31'd0, src_we}, 32'd0);
      end
      if (state == ST_COPY) begin
        copy_cyc++;
        check_val("int_we_in_copy", {31'd0, int_we}, 32'd0);
      end
      if (int_we) begin
        int_wr_cnt++;
        if (exp_q.size() == 0) check_val("extra_int_write", 32'(exp_q.size()), 32'd1);
        else check_val("int_write", {16'd0, int_waddr, int_wdata}, {16'd0, exp_q.pop_front()});
      end
      if (src_we) begin
        src_wr_cnt++;
        if (exp_q.size() == 0) check_val("extra_src_write", 32'(exp_q.size()), 32'd1);
        else check_val("src_write", {16'd0, src_waddr, src_wdata}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // push expected int writes (and source write-backs when with_copy)
  task automatic build_exp(input bit with_copy);
    logic [7:0] nxt [L];
    int a, b, c, v;
    for (int i = 0; i < L; i++) begin
      a = (i > 0)     ? sx(src_model[i-1]) : 0;
      b = sx(src_model[i]);
      c = (i < L - 1) ? sx(src_model[i+1]) : 0;
      v = (a + 2 * b + c) >>> 2;
      nxt[i] = v[7:0];
      exp_q.push_back({8'(i), nxt[i]});
    end
    if (with_copy) begin
      for (int i = 0; i < L; i++) begin
        exp_q.push_back({8'(i), nxt[i]});
        src_model[i] = nxt[i];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_src();
    for (int i = 0; i < L; i++) src_init[i] = src_model[i];
    @(negedge clk) ld_all = 1'b1;
    @(negedge clk) ld_all = 1'b0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < L; i++) src_model[i] = v;
  endtask

  task automatic run_pass(input string tag, input int hold);
    int n, nerr;
    build_exp(1'b1);
    smooth_cyc = 0; copy_cyc = 0; int_wr_cnt = 0; src_wr_cnt = 0;
    @(negedge clk) start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 4 * L && !(exp_q.size() == 0 && state == ST_IDLE)) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check_val({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_int_writes"}, 32'(int_wr_cnt), 32'(L));
    check_val({tag, "_src_writes"}, 32'(src_wr_cnt), 32'(L));
    check_val({tag, "_smooth_len"}, {31'd0, smooth_cyc > 0 && smooth_cyc <= L + 4}, 32'd1);
    check_val({tag, "_copy_len"}, {31'd0, copy_cyc > 0 && copy_cyc <= L + 3}, 32'd1);
    nerr = 0;
    for (int i = 0; i < L; i++) if (src_mem[i] !== src_model[i]) nerr++;
    check_val({tag, "_src_final"}, 32'(nerr), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; ld_all = 1'b0;
    for (int i = 0; i < L; i++) begin
      src_mem[i] = '0; int_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_val("rst_state", {30'd0, state}, 32'd0);
    check_val("rst_we", {30'd0, int_we, src_we}, 32'd0);
    check_val("rst_addr", {src_raddr, src_waddr, int_raddr, int_waddr}, 32'd0);
    check_val("rst_wdata", {16'd0, src_wdata, int_wdata}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // all ones
    fill(8'd1); load_src();
    run_pass("ones", 1);
    check_val("ones_int0", {24'd0, int_mem[0]}, 32'h00);
    check_val("ones_int1", {24'd0, int_mem[1]}, 32'h01);
    check_val("ones_int254", {24'd0, int_mem[254]}, 32'h01);
    check_val("ones_int255", {24'd0, int_mem[255]}, 32'h00);

    // impulse
    fill(8'd0); src_model[10] = 8'd64; load_src();
    run_pass("impulse", 1);
    check_val("imp_int9", {24'd0, int_mem[9]}, 32'h10);
    check_val("imp_int10", {24'd0, int_mem[10]}, 32'h20);
    check_val("imp_int11", {24'd0, int_mem[11]}, 32'h10);
    check_val("imp_int12", {24'd0, int_mem[12]}, 32'h00);

    // extremes
    fill(8'd127); load_src();
    run_pass("max", 1);
    check_val("max_end0", {24'd0, int_mem[0]}, 32'd95);
    check_val("max_mid", {24'd0, int_mem[100]}, 32'd127);
    check_val("max_end255", {24'd0, int_mem[255]}, 32'd95);
    fill(8'h80); load_src();
    run_pass("min", 1);
    check_val("min_end0", {24'd0, int_mem[0]}, 32'hA0);
    check_val("min_mid", {24'd0, int_mem[100]}, 32'h80);
    check_val("min_end255", {24'd0, int_mem[255]}, 32'hA0);

    // negative floor
    fill(8'd0); src_model[5] = 8'hFF; load_src();
    run_pass("floor", 1);
    check_val("floor_int4", {24'd0, int_mem[4]}, 32'hFF);
    check_val("floor_int5", {24'd0, int_mem[5]}, 32'hFF);
    check_val("floor_int6", {24'd0, int_mem[6]}, 32'hFF);
    check_val("floor_int7", {24'd0, int_mem[7]}, 32'h00);

    // random data, then a second pass on the updated source
    for (int i = 0; i < L; i++) src_model[i] = 8'($urandom_range(0, 255));
    load_src();
    run_pass("rand1", 1);
    run_pass("rand2", 1);

    // START held high: exactly one pass
    for (int i = 0; i < L; i++) src_model[i] = 8'($urandom_range(0, 255));
    load_src();
    run_pass("hold", 3 * L);

    // reset 50 cycles into SMOOTH, then a clean pass
    for (int i = 0; i < L; i++) src_model[i] = 8'($urandom_range(0, 255));
    load_src();
    build_exp(1'b0);
    smooth_cyc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (n < 200 && smooth_cyc < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("abort_reached_smooth", {31'd0, smooth_cyc >= 50}, 32'd1);
    check_val("abort_we_before", {31'd0, int_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_we_async", {30'd0, int_we, src_we}, 32'd0);
    check_val("abort_state_async", {30'd0, state}, 32'd0);
    check_val("abort_addr_async", {src_raddr, src_waddr, int_raddr, int_waddr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    run_pass("after_abort", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
